// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - key codes, FSM state encoding and defaults for numeric entry
package teclado_pkg;

    localparam int N_DIGITOS_DEF = 4;
    localparam int ANCHO_BIN_DEF = 14;

    localparam logic [3:0] TECLA_ENTER   = 4'hA;
    localparam logic [3:0] TECLA_BORRAR  = 4'hB;
    localparam logic [3:0] TECLA_LIMPIAR = 4'hC;
    localparam logic [3:0] DIGITO_MAX    = 4'h9;

    typedef enum logic [1:0] {
        EDITANDO     = 2'd0,
        CONVIRTIENDO = 2'd1,
        LISTO        = 2'd2
    } estado_t;

endpackage

// File: rtl/entrada_numero_if.sv
// rtl/entrada_numero_if.sv - key input and entry/result outputs of the numeric entry block
interface entrada_numero_if #(
    parameter int N_DIGITOS = 4,
    parameter int ANCHO_BIN = 14
);
    logic [4:0]             digito;
    logic [4*N_DIGITOS-1:0] bcd;
    logic [2:0]             n_dig;
    logic                   ocupado;
    logic [ANCHO_BIN-1:0]   numero;
    logic                   numero_valido;
    logic                   error;

    modport master (
        output digito,
        input  bcd, n_dig, ocupado, numero, numero_valido, error
    );

    modport slave (
        input  digito,
        output bcd, n_dig, ocupado, numero, numero_valido, error
    );
endinterface

// File: rtl/conversor_bcd_bin.sv
// rtl/conversor_bcd_bin.sv - fixed-latency BCD to binary converter, MSB digit first
module conversor_bcd_bin #(
    parameter int N_DIGITOS = 4,
    parameter int ANCHO_BIN = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*N_DIGITOS-1:0] bcd,
    output logic                   done,
    output logic [ANCHO_BIN-1:0]   acc
);
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    logic          busy;
    logic [IW-1:0] idx;
    logic [3:0]    dig;
    logic [ANCHO_BIN+3:0] ext;
    logic [ANCHO_BIN+3:0] prod;
    logic [ANCHO_BIN-1:0] siguiente;

    // Select the digit under the index and form acc*10 + digit with shifts.
    always_comb begin
        dig = 4'h0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (idx == IW'(i)) dig = bcd[4*i +: 4];
        end
        ext       = {4'h0, acc};
        prod      = (ext << 3) + (ext << 1) + {{ANCHO_BIN{1'b0}}, dig};
        siguiente = ANCHO_BIN'(prod);
    end

    // Last step is the cycle where the index reaches digit 0.
    assign done = busy && (idx == '0);

    // Walk all N digits every time; unused upper nibbles are zero, so latency is constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            idx  <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= IW'(N_DIGITOS - 1);
            acc  <= '0;
        end else if (busy) begin
            acc <= siguiente;
            if (idx == '0) busy <= 1'b0;
            else           idx  <= idx - 1'b1;
        end
    end
endmodule

// File: rtl/entrada_numero.sv
// rtl/entrada_numero.sv - keypad digit entry buffer with backspace/clear and conversion on ENTER
module entrada_numero
    import teclado_pkg::*;
#(
    parameter int N_DIGITOS = N_DIGITOS_DEF,
    parameter int ANCHO_BIN = ANCHO_BIN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    entrada_numero_if.slave  bus
);
    localparam int AB = 4 * N_DIGITOS;

    estado_t              estado;
    logic [AB-1:0]        bcd;
    logic [2:0]           n_dig;
    logic                 ocupado;
    logic [ANCHO_BIN-1:0] numero;
    logic                 numero_valido;
    logic                 error;

    logic                 strobe;
    logic [3:0]           codigo;
    logic                 conv_start;
    logic                 conv_done;
    logic [ANCHO_BIN-1:0] conv_acc;

    assign strobe = bus.digito[4];
    assign codigo = bus.digito[3:0];

    // Conversion launches on the same edge the FSM leaves EDITANDO.
    assign conv_start = (estado == EDITANDO) && strobe &&
                        (codigo == TECLA_ENTER) && (n_dig != 3'd0);

    conversor_bcd_bin #(
        .N_DIGITOS (N_DIGITOS),
        .ANCHO_BIN (ANCHO_BIN)
    ) u_conversor (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bcd   (bcd),
        .done  (conv_done),
        .acc   (conv_acc)
    );

    // Entry FSM: edit buffer, wait for converter, publish result and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado        <= EDITANDO;
            bcd           <= '0;
            n_dig         <= 3'd0;
            ocupado       <= 1'b0;
            numero        <= '0;
            numero_valido <= 1'b0;
            error         <= 1'b0;
        end else begin
            numero_valido <= 1'b0;
            error         <= 1'b0;
            case (estado)
                EDITANDO: begin
                    if (strobe) begin
                        if (codigo <= DIGITO_MAX) begin
                            if (n_dig < 3'(N_DIGITOS)) begin
                                bcd   <= (bcd << 4) | AB'(codigo);
                                n_dig <= n_dig + 3'd1;
                            end else begin
                                error <= 1'b1;
                            end
                        end else if (codigo == TECLA_BORRAR) begin
                            if (n_dig != 3'd0) begin
                                bcd   <= bcd >> 4;
                                n_dig <= n_dig - 3'd1;
                            end
                        end else if (codigo == TECLA_LIMPIAR) begin
                            bcd   <= '0;
                            n_dig <= 3'd0;
                        end else if (codigo == TECLA_ENTER) begin
                            if (n_dig != 3'd0) begin
                                estado  <= CONVIRTIENDO;
                                ocupado <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                end
                CONVIRTIENDO: begin
                    if (strobe) error <= 1'b1;
                    if (conv_done) begin
                        estado  <= LISTO;
                        ocupado <= 1'b0;
                    end
                end
                LISTO: begin
                    numero        <= conv_acc;
                    numero_valido <= 1'b1;
                    bcd           <= '0;
                    n_dig         <= 3'd0;
                    estado        <= EDITANDO;
                end
                default: estado <= EDITANDO;
            endcase
        end
    end

    assign bus.bcd           = bcd;
    assign bus.n_dig         = n_dig;
    assign bus.ocupado       = ocupado;
    assign bus.numero        = numero;
    assign bus.numero_valido = numero_valido;
    assign bus.error         = error;
endmodule

// File: tb/tb_entrada_numero.sv
// tb/tb_entrada_numero.sv - directed scoreboard bench for entrada_numero
module tb_entrada_numero;
    localparam int N  = 4;
    localparam int AB = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    entrada_numero_if #(.N_DIGITOS(N), .ANCHO_BIN(AB)) bus ();

    entrada_numero #(.N_DIGITOS(N), .ANCHO_BIN(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int n_validos = 0;
    int esperados[$];

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One key press: strobe for one edge, return the error flag seen after it.
    task automatic tecla(input logic [3:0] c, output logic err);
        @(negedge clk);
        bus.digito = {1'b1, c};
        @(negedge clk);
        bus.digito = 5'd0;
        err = bus.error;
    endtask

    // After ENTER: count remaining busy cycles, then expect the result pulse.
    task automatic esperar_fin(input string tag, input int ocup_restantes);
        int cnt;
        cnt = 0;
        while (bus.ocupado === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chequear({tag, "_ocupado_ciclos"}, cnt, ocup_restantes);
        @(negedge clk);
        chequear({tag, "_valido"}, bus.numero_valido, 1);
        chequear({tag, "_bcd_limpio"}, bus.bcd, 0);
        chequear({tag, "_ndig_limpio"}, bus.n_dig, 0);
    endtask

    // Scoreboard: every result pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (bus.numero_valido === 1'b1) begin
            n_validos++;
            if (esperados.size() == 0) begin
                chequear("valido_inesperado", 1, 0);
            end else begin
                chequear("numero", bus.numero, esperados.pop_front());
            end
        end
    end

    initial begin
        logic e;
        bus.digito = 5'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chequear("rst_bcd", bus.bcd, 0);
        chequear("rst_ndig", bus.n_dig, 0);
        chequear("rst_ocupado", bus.ocupado, 0);
        chequear("rst_numero", bus.numero, 0);
        chequear("rst_valido", bus.numero_valido, 0);
        chequear("rst_error", bus.error, 0);
        rst = 1'b0;

        // 1) 1,2,3,4,ENTER
        tecla(4'h1, e); tecla(4'h2, e); tecla(4'h3, e); tecla(4'h4, e);
        chequear("t1_bcd", bus.bcd, 32'h1234);
        chequear("t1_ndig", bus.n_dig, 4);
        esperados.push_back(1234);
        tecla(4'hA, e);
        chequear("t1_enter_err", e, 0);
        esperar_fin("t1", N);

        // 2) full buffer rejects a fifth digit
        tecla(4'h9, e); tecla(4'h9, e); tecla(4'h9, e); tecla(4'h9, e);
        tecla(4'h5, e);
        chequear("t2_lleno_err", e, 1);
        chequear("t2_bcd", bus.bcd, 32'h9999);
        chequear("t2_ndig", bus.n_dig, 4);
        esperados.push_back(9999);
        tecla(4'hA, e);
        esperar_fin("t2", N);

        // 3) backspace past empty is silent
        tecla(4'h7, e);
        tecla(4'hB, e);
        chequear("t3_borrar_ndig", bus.n_dig, 0);
        tecla(4'hB, e);
        chequear("t3_borrar_vacio_err", e, 0);
        tecla(4'hB, e);
        chequear("t3_borrar_vacio_err2", e, 0);
        tecla(4'hE, e);
        chequear("t3_codigo_E_err", e, 0);
        tecla(4'h3, e);
        chequear("t3_bcd", bus.bcd, 32'h0003);
        chequear("t3_ndig", bus.n_dig, 1);
        esperados.push_back(3);
        tecla(4'hA, e);
        esperar_fin("t3", N);

        // 4) ENTER with empty buffer, and after LIMPIAR
        tecla(4'hA, e);
        chequear("t4_enter_vacio_err", e, 1);
        chequear("t4_ocupado", bus.ocupado, 0);
        tecla(4'h4, e); tecla(4'h2, e);
        chequear("t4_bcd42", bus.bcd, 32'h0042);
        tecla(4'hC, e);
        chequear("t4_limpiar_bcd", bus.bcd, 0);
        chequear("t4_limpiar_ndig", bus.n_dig, 0);
        tecla(4'hA, e);
        chequear("t4_enter_vacio_err2", e, 1);
        @(negedge clk);
        chequear("t4_ocupado2", bus.ocupado, 0);
        chequear("t4_numero_igual", bus.numero, 3);

        // 5) key strobed while converting is dropped with error
        tecla(4'h5, e);
        esperados.push_back(5);
        tecla(4'hA, e);
        chequear("t5_ocupado", bus.ocupado, 1);
        tecla(4'h8, e);
        chequear("t5_ocupado_err", e, 1);
        esperar_fin("t5", N - 2);

        // 6) reset during the second conversion cycle aborts
        tecla(4'h1, e); tecla(4'h2, e); tecla(4'h3, e); tecla(4'h4, e);
        tecla(4'hA, e);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chequear("t6_rst_bcd", bus.bcd, 0);
        chequear("t6_rst_ndig", bus.n_dig, 0);
        chequear("t6_rst_ocupado", bus.ocupado, 0);
        chequear("t6_rst_numero", bus.numero, 0);
        chequear("t6_rst_valido", bus.numero_valido, 0);
        repeat (10) @(negedge clk);
        tecla(4'h6, e);
        esperados.push_back(6);
        tecla(4'hA, e);
        esperar_fin("t6", N);

        repeat (3) @(negedge clk);
        chequear("pulsos_validos", n_validos, 5);
        chequear("cola_vacia", esperados.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
